// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - pipeline-stalling 32-bit load/store bridge onto a 16-bit async SRAM
module sram_controller #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // One bit wider than the nominal 4-bit count so WAIT_CYCLES=15 can reach 16.
  localparam logic [4:0] LAST_CNT = 5'(WAIT_CYCLES + 1);

  state_t      state, state_next;
  logic [4:0]  cnt, cnt_next;
  logic        load;
  logic [15:0] idx;
  logic [31:0] wdata;
  logic        op_write;
  logic        xfer;
  logic [15:0] dq_out;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{address[31:18], address[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      wdata    <= '0;
      op_write <= 1'b0;
      readdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        idx      <= address[17:2];
        wdata    <= writedata;
        op_write <= wr_en;
      end
      if (xfer && !op_write) begin
        if (cnt[0]) readdata[31:16] <= SRAM_DQ;
        else        readdata[15:0]  <= SRAM_DQ;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = ~(wr_en | rd_en);
        if (wr_en || rd_en) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == LAST_CNT) state_next = DONE;
        else                 cnt_next   = cnt + 5'd1;
      end
      DONE: begin
        // Returning to IDLE unconditionally keeps a held request from retriggering here.
        ready      = 1'b1;
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset releases the bus at once.
  assign xfer      = (state == ACCESS) && (cnt[4:1] == 4'd0);
  assign SRAM_WE_N = ~(xfer & op_write);
  assign SRAM_OE_N = ~(xfer & ~op_write);
  assign SRAM_ADDR = xfer ? {1'b0, idx, cnt[0]} : 18'd0;
  assign dq_out    = cnt[0] ? wdata[31:16] : wdata[15:0];
  assign SRAM_DQ   = (xfer && op_write) ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller with an SRAM model
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, rd_en, ready;
  logic [31:0] address, writedata, readdata;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  logic        wr_en1, rd_en1, ready1;
  logic [31:0] address1, writedata1, readdata1;
  wire  [15:0] dq1;
  logic [17:0] addr1;
  logic        we1_n, oe1_n, ce1_n, ub1_n, lb1_n;

  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .writedata(writedata), .readdata(readdata), .ready(ready), .SRAM_DQ(SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  sram_controller #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .writedata(writedata1), .readdata(readdata1), .ready(ready1), .SRAM_DQ(dq1),
    .SRAM_ADDR(addr1), .SRAM_WE_N(we1_n), .SRAM_OE_N(oe1_n),
    .SRAM_CE_N(ce1_n), .SRAM_UB_N(ub1_n), .SRAM_LB_N(lb1_n)
  );

  logic [15:0] mem [0:1023];
  assign SRAM_DQ = !SRAM_OE_N ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;
  assign dq1     = !oe1_n ? 16'h5A5A : 16'hzzzz;

  logic [33:0] exp_wq[$];
  logic [33:0] obs_q[$];
  logic [31:0] exp_rq[$];
  int oe_cnt = 0;

  always @(negedge clk) begin
    if (!SRAM_WE_N) begin
      mem[SRAM_ADDR[9:0]] <= SRAM_DQ;
      obs_q.push_back({SRAM_ADDR, SRAM_DQ});
    end
    if (!SRAM_OE_N) oe_cnt++;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string name);
    logic [33:0] e;
    while (exp_wq.size() > 0) begin
      e = exp_wq.pop_front();
      if (obs_q.size() == 0) begin
        total++; bad++;
        $display("FAIL %s missing write actual=none required=%0h", name, e);
      end else begin
        chk({name, "_wr"}, 64'(obs_q.pop_front()), 64'(e));
      end
    end
    while (obs_q.size() > 0) begin
      total++; bad++;
      $display("FAIL %s extra write actual=%0h required=none", name, obs_q.pop_front());
    end
  endtask

  // Drives a request at a negedge and returns at the negedge where ready is high (DONE).
  task automatic run_op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int lat, input string name);
    int n;
    if (wr) begin
      exp_wq.push_back({1'b0, a[17:2], 1'b0, d[15:0]});
      exp_wq.push_back({1'b0, a[17:2], 1'b1, d[31:16]});
    end
    exp_rq.push_back(exp_rd);
    wr_en = wr; rd_en = rd; address = a; writedata = d;
    #1 chk({name, "_stall0"}, 64'(ready), 64'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (ready) break;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_readdata"}, 64'(readdata), 64'(exp_rq.pop_front()));
  endtask

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n;
    int oe0;
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0404, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_000B, 32'hA5A5_0F0F, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         32'hA5A5_0F0F};
    vecs[4] = '{1'b1, 1'b0, 32'h0003_FFFC, 32'hCAFE_F00D, 32'hA5A5_0F0F};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFC_0404, 32'h0,         32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b1, 32'h0003_FFFC, 32'h0,         32'hCAFE_F00D};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hCAFE_F00D};
    vecs[8] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'h1234_5678};

    rst = 1'b1; wr_en = 0; rd_en = 0; address = 0; writedata = 0;
    wr_en1 = 0; rd_en1 = 0; address1 = 0; writedata1 = 0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_strobes", 64'({SRAM_WE_N, SRAM_OE_N}), 64'b11);
    chk("rst_readdata", 64'(readdata), 64'd0);
    chk("rst_addr", 64'(SRAM_ADDR), 64'd0);
    chk("tied_low", 64'({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("release_ready", 64'(ready), 64'd1);

    // Short-wait instance: read at T, ready at T+4.
    @(negedge clk);
    rd_en1 = 1'b1; address1 = 32'h0000_0040;
    #1 chk("w1_stall0", 64'(ready1), 64'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (ready1) break;
    end
    chk("w1_latency", 64'(n), 64'd4);
    chk("w1_readdata", 64'(readdata1), 64'h5A5A_5A5A);
    rd_en1 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 6,
             $sformatf("vec%0d", i));
      wr_en = 0; rd_en = 0;
      @(negedge clk);
      #1 check_writes($sformatf("vec%0d", i));
    end

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1 chk("idle", 64'({ready, SRAM_WE_N, SRAM_OE_N}), 64'b111);
    end
    check_writes("idle");

    // Held read: one read per pass, second starts on the IDLE cycle after DONE.
    @(negedge clk);
    oe0 = oe_cnt;
    run_op(1'b0, 1'b1, 32'h0000_0008, 32'h0, 32'hA5A5_0F0F, 6, "held1");
    @(negedge clk);
    #1 chk("held_idle_ready", 64'(ready), 64'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (ready) break;
    end
    chk("held2_latency", 64'(n), 64'd6);
    chk("held_reads", 64'(oe_cnt - oe0), 64'd4);
    rd_en = 0;
    @(negedge clk);

    // Reset during the high-half write cycle.
    exp_wq.push_back({1'b0, 16'h0008, 1'b0, 16'h2222});
    exp_wq.push_back({1'b0, 16'h0008, 1'b1, 16'h1111});
    wr_en = 1'b1; address = 32'h0000_0020; writedata = 32'h1111_2222;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_strobes", 64'({SRAM_WE_N, SRAM_OE_N}), 64'b11);
    chk("abort_readdata", 64'(readdata), 64'd0);
    chk("abort_addr", 64'(SRAM_ADDR), 64'd0);
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_release_ready", 64'(ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1 chk("abort_quiet", 64'({ready, SRAM_WE_N, SRAM_OE_N}), 64'b111);
    end
    check_writes("abort");

    run_op(1'b0, 1'b1, 32'h0000_0404, 32'h0, 32'hDEAD_BEEF, 6, "post_abort");
    rd_en = 0;
    @(negedge clk);
    #1 check_writes("post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, sets the number of bus-idle settle cycles after the two half-word transfers; the legal range is 1-15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 wr_en  input  1  MEM-stage store request; level, held until ready is seen high.
REQ-005 rd_en  input  1  MEM-stage load request; level, held until ready is seen high.
REQ-006 address  input  32  byte address from the ALU result; word index is address[17:2], and address[1:0] is ignored.
REQ-007 writedata  input  32  store data.
REQ-008 readdata  output  32  load data; registered.
REQ-009 ready  output  1  high means the pipeline may advance; low means freeze all pipeline registers.
REQ-010 SRAM_DQ  inout  16  SRAM data bus.
REQ-011 SRAM_ADDR  output  18  half-word address, formed as {1'b0, word index, half}.
REQ-012 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM strobes.

Function
REQ-013 States: IDLE, ACCESS, DONE; a 4-bit counter cnt runs in ACCESS.
REQ-014 IDLE: ready = ~(wr_en | rd_en), combinational, so a new request freezes the pipeline in the same cycle.
REQ-015 IDLE with wr_en or rd_en high: latch address[17:2], writedata and op (write if wr_en, else read), set cnt=0, go to ACCESS.
REQ-016 Simultaneous wr_en and rd_en: the request is treated as a write, and no read occurs.
REQ-017 ACCESS cnt=0, low half: SRAM_ADDR = {1'b0, idx, 1'b0}.
  - Write: SRAM_DQ = wdata[15:0], SRAM_WE_N=0.
  - Read: SRAM_OE_N=0, and readdata[15:0] captures SRAM_DQ at the cycle end.
REQ-018 ACCESS cnt=1, high half: SRAM_ADDR = {1'b0, idx, 1'b1}.
  - Write: SRAM_DQ = wdata[31:16], SRAM_WE_N=0.
  - Read: SRAM_OE_N=0, and readdata[31:16] captures SRAM_DQ.
REQ-019 ACCESS cnt=2 .. 1+WAIT_CYCLES: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z; on cnt=1+WAIT_CYCLES, go to DONE.
REQ-020 In ACCESS, ready=0 regardless of wr_en/rd_en.
REQ-021 DONE: ready=1 for exactly one cycle, then unconditional transition to IDLE; a request still high in DONE is not restarted.
REQ-022 Latency: for a request first seen in IDLE at cycle T, ready is low for cycles T..T+2+WAIT_CYCLES and high at T+3+WAIT_CYCLES (default: 6 stall cycles, high at T+6).
REQ-023 SRAM_DQ is driven only in write cycles cnt=0 and cnt=1; it is high-Z in all other cycles.
REQ-024 SRAM_CE_N, SRAM_UB_N and SRAM_LB_N are tied 0.
REQ-025 readdata changes only on read capture; it holds its value through writes and idle cycles.
REQ-026 Inputs that change during ACCESS are ignored; only the values latched in IDLE are used.
REQ-027 wr_en/rd_en low in IDLE: stay in IDLE, ready=1, no SRAM activity (WE_N=1, OE_N=1, DQ high-Z).

Reset
REQ-028 rst low, asynchronous: state=IDLE, cnt=0, readdata=0, latched address and data=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z, SRAM_ADDR=0.
REQ-029 Reset asserted mid-ACCESS: the operation is aborted immediately; WE_N returns high within the reset assertion, and no further SRAM cycle occurs.
REQ-030 After reset release: ready = ~(wr_en | rd_en) from the first cycle.

Verification
REQ-031 Write then read: wr_en with address=0x0000_0404, writedata=0xDEAD_BEEF.
  - Write cycles: SRAM_ADDR=0x00202 carries 0xBEEF, SRAM_ADDR=0x00203 carries 0xDEAD.
  - ready is high at T+6.
  - A following read of 0x404 returns readdata=0xDEADBEEF at T+6.
REQ-032 Idle: wr_en=rd_en=0 for 20 cycles -> ready=1 throughout, WE_N=OE_N=1, DQ high-Z.
REQ-033 Dual request: wr_en=rd_en=1 with writedata=0x1234_5678 -> a write occurs; readdata stays unchanged.
REQ-034 Held request: rd_en held high through DONE -> exactly one read per assertion; a new read starts on the IDLE cycle after DONE with ready=0 that cycle.
REQ-035 Reset during write: rst pulled low at cnt=1 -> WE_N=1 and DQ high-Z immediately; readdata=0; state IDLE after release.
REQ-036 WAIT_CYCLES=1: a read request at T gives ready high at T+4.
